// File: rtl/smart_house_cmd_decoder.sv
// Purpose : parse ASCII keypad/serial bytes into smart-house toggle pulses and a temperature set-point.
// Latency : toggle/error pulses one cycle after the accepting edge; temp_req/temp_update one edge after EXEC.
// Backpr. : char_ready drops only for the single EXEC cycle after '#'; otherwise a byte is taken every cycle.
module smart_house_cmd_decoder #(
  parameter int TEMP_W       = 32,
  parameter int TEMP_DEFAULT = 25,
  parameter int TEMP_MAX     = 50,
  parameter int MAX_DIGITS   = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_in,
  output logic              char_ready,
  output logic              music_req,
  output logic              light_req,
  output logic              curtain_req,
  output logic [TEMP_W-1:0] temp_req,
  output logic              temp_update,
  output logic [7:0]        char_req,
  output logic              cmd_error
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CH_M     = 8'h4D;
  localparam logic [7:0] CH_L     = 8'h4C;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_HASH  = 8'h23;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEMP = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TEMP_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic [7:0]        char_q, char_d;
  logic              music_q, music_d;
  logic              light_q, light_d;
  logic              curtain_q, curtain_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;

  logic accept;
  logic is_digit;

  assign char_ready = (state_q != S_EXEC);
  assign accept     = char_valid && char_ready;
  assign is_digit   = (char_in >= CH_0) && (char_in <= CH_9);

  // State and output registers; async reset drops any partial command at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      temp_q    <= TEMP_W'(TEMP_DEFAULT);
      char_q    <= 8'h00;
      music_q   <= 1'b0;
      light_q   <= 1'b0;
      curtain_q <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      temp_q    <= temp_d;
      char_q    <= char_d;
      music_q   <= music_d;
      light_q   <= light_d;
      curtain_q <= curtain_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
    end
  end

  // Next-state decode: command parsing, digit accumulation, idle timeout and set-point commit.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    temp_d    = temp_q;
    char_d    = char_q;
    music_d   = 1'b0;
    light_d   = 1'b0;
    curtain_d = 1'b0;
    upd_d     = 1'b0;
    err_d     = 1'b0;

    // Every accepted byte is echoed, rejected ones included.
    if (accept) begin
      char_d = char_in;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (char_in)
            CH_M:     music_d   = 1'b1;
            CH_L:     light_d   = 1'b1;
            CH_C:     curtain_d = 1'b1;
            CH_SPACE: ;
            CH_T: begin
              state_d = S_TEMP;
              acc_d   = '0;
              cnt_d   = '0;
              tmr_d   = '0;
            end
            default:  err_d = 1'b1;
          endcase
        end
      end

      S_TEMP: begin
        if (accept) begin
          tmr_d = '0;
          if (is_digit) begin
            if (cnt_q == CNT_W'(MAX_DIGITS)) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              // ASCII '0'..'9' carry the digit value in their low nibble.
              acc_d = acc_q * TEMP_W'(10) + TEMP_W'(char_in[3:0]);
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (char_in == CH_HASH) begin
            if (cnt_q != '0) begin
              state_d = S_EXEC;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            // Stray byte aborts the set-point; it is not re-read as a new command.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_EXEC: begin
        // Over-range set-points saturate silently.
        temp_d  = (acc_q > TEMP_W'(TEMP_MAX)) ? TEMP_W'(TEMP_MAX) : acc_q;
        upd_d   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign music_req   = music_q;
  assign light_req   = light_q;
  assign curtain_req = curtain_q;
  assign temp_req    = temp_q;
  assign temp_update = upd_q;
  assign char_req    = char_q;
  assign cmd_error   = err_q;

endmodule

// File: tb/tb_smart_house_cmd_decoder.sv
// Bench for smart_house_cmd_decoder: directed plan sequences plus random byte streams.
// Reference model keeps the pending command as a digit queue and an idle-cycle count.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_smart_house_cmd_decoder;

  localparam int TEMP_W       = 32;
  localparam int TEMP_DEFAULT = 25;
  localparam int TEMP_MAX     = 50;
  localparam int MAX_DIGITS   = 3;
  localparam int TIMEOUT      = 16;

  logic              clock;
  logic              reset;
  logic              char_valid;
  logic [7:0]        char_in;
  logic              char_ready;
  logic              music_req;
  logic              light_req;
  logic              curtain_req;
  logic [TEMP_W-1:0] temp_req;
  logic              temp_update;
  logic [7:0]        char_req;
  logic              cmd_error;

  smart_house_cmd_decoder #(
    .TEMP_W      (TEMP_W),
    .TEMP_DEFAULT(TEMP_DEFAULT),
    .TEMP_MAX    (TEMP_MAX),
    .MAX_DIGITS  (MAX_DIGITS),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .char_valid (char_valid),
    .char_in    (char_in),
    .char_ready (char_ready),
    .music_req  (music_req),
    .light_req  (light_req),
    .curtain_req(curtain_req),
    .temp_req   (temp_req),
    .temp_update(temp_update),
    .char_req   (char_req),
    .cmd_error  (cmd_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = waiting for command, 1 = collecting set-point, 2 = committing.
  int   m_mode;
  int   m_digits[$];
  int   m_idle;
  int   m_temp;
  int   m_char;
  bit   e_music, e_light, e_curtain, e_upd, e_err;

  logic [7:0] pool [0:11] = '{8'h4D, 8'h4C, 8'h43, 8'h54, 8'h20, 8'h23,
                              8'h58, 8'h6D, 8'h54, 8'h23, 8'h41, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_digits.delete();
    m_idle = 0;
    m_temp = TEMP_DEFAULT;
    m_char = 0;
    e_music = 0; e_light = 0; e_curtain = 0; e_upd = 0; e_err = 0;
  endtask

  // Advance the model across one rising edge with the given input.
  task automatic model_edge(input bit v, input logic [7:0] ch);
    bit acc;
    e_music = 0; e_light = 0; e_curtain = 0; e_upd = 0; e_err = 0;
    acc = v && (m_mode != 2);
    if (acc) m_char = ch;
    if (m_mode == 2) begin
      m_temp = (digits_value() > TEMP_MAX) ? TEMP_MAX : digits_value();
      e_upd  = 1;
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (acc) begin
        if (ch == "M") e_music = 1;
        else if (ch == "L") e_light = 1;
        else if (ch == "C") e_curtain = 1;
        else if (ch == "T") begin
          m_mode = 1;
          m_digits.delete();
          m_idle = 0;
        end else if (ch != " ") e_err = 1;
      end
    end else begin
      if (acc) begin
        m_idle = 0;
        if (ch >= "0" && ch <= "9") begin
          if (m_digits.size() == MAX_DIGITS) begin
            e_err = 1; m_mode = 0;
          end else m_digits.push_back(int'(ch) - 48);
        end else if (ch == "#") begin
          if (m_digits.size() > 0) m_mode = 2;
          else begin e_err = 1; m_mode = 0; end
        end else begin
          e_err = 1; m_mode = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          e_err = 1; m_mode = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    int hi;
    chk("char_ready",  32'(char_ready),  32'(m_mode != 2));
    chk("music_req",   32'(music_req),   32'(e_music));
    chk("light_req",   32'(light_req),   32'(e_light));
    chk("curtain_req", 32'(curtain_req), 32'(e_curtain));
    chk("temp_update", 32'(temp_update), 32'(e_upd));
    chk("cmd_error",   32'(cmd_error),   32'(e_err));
    chk("temp_req",    temp_req,         32'(m_temp));
    chk("char_req",    32'(char_req),    32'(m_char));
    hi = int'(music_req) + int'(light_req) + int'(curtain_req) + int'(temp_update) + int'(cmd_error);
    chk("pulse_overlap", 32'(hi > 1), 32'(0));
  endtask

  // Drive one cycle (called 1 unit after a rising edge), then check after the next edge.
  task automatic step(input bit v, input logic [7:0] ch);
    char_valid = v;
    char_in    = ch;
    @(posedge clock);
    #1;
    model_edge(v, ch);
    check_all();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    char_valid = 1'b0;
    reset      = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    check_all();
    chk("rst_temp_req", temp_req, 32'(TEMP_DEFAULT));
    chk("rst_char_ready", 32'(char_ready), 32'd1);

    // Idle cycles after reset.
    repeat (3) step(1'b0, 8'h00);

    // Toggle commands back to back.
    step(1'b1, "M"); chk("plan_music", 32'(music_req), 32'd1);
    step(1'b1, "L"); chk("plan_light", 32'(light_req), 32'd1);
    step(1'b1, "C"); chk("plan_curtain", 32'(curtain_req), 32'd1);
    step(1'b0, 8'h00);
    chk("plan_char_req_C", 32'(char_req), 32'h43);

    // Set-point 30, then clamped 99.
    send_str("T30#");
    chk("plan_exec_ready_low", 32'(char_ready), 32'd0);
    step(1'b1, "M");
    chk("plan_temp30", temp_req, 32'd30);
    chk("plan_upd30", 32'(temp_update), 32'd1);
    send_str("T99#");
    step(1'b0, 8'h00);
    chk("plan_temp_clamp", temp_req, 32'd50);
    chk("plan_clamp_noerr", 32'(cmd_error), 32'd0);

    // Malformed commands.
    send_str("T1234");
    chk("plan_too_many_digits", 32'(cmd_error), 32'd1);
    chk("plan_temp_kept", temp_req, 32'd50);
    send_str("T#");
    chk("plan_hash_no_digits", 32'(cmd_error), 32'd1);
    send_str("X");
    chk("plan_bad_idle", 32'(cmd_error), 32'd1);
    send_str(" ");
    chk("plan_space_quiet", 32'(cmd_error), 32'd0);

    // Idle timeout mid set-point.
    send_str("T2");
    for (int i = 0; i < TIMEOUT; i++) begin
      step(1'b0, 8'h00);
      chk("plan_timeout", 32'(cmd_error), 32'(i == TIMEOUT - 1));
    end
    step(1'b1, "M");
    chk("plan_after_timeout_M", 32'(music_req), 32'd1);

    // Reset in the middle of a set-point.
    send_str("T4");
    async_reset();
    chk("plan_rst_temp", temp_req, 32'(TEMP_DEFAULT));
    send_str("#");
    chk("plan_hash_after_rst", 32'(cmd_error), 32'd1);
    chk("plan_temp_after_rst", temp_req, 32'(TEMP_DEFAULT));

    // Random byte streams checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 4) begin
        repeat ($urandom_range(8, 20)) step(1'b0, 8'h00);
      end else if (r == 4) begin
        async_reset();
      end else if (r < 30) begin
        step(1'b1, "T");
      end else begin
        logic [7:0] ch;
        if ($urandom_range(0, 9) < 4) ch = 8'h30 + 8'($urandom_range(0, 9));
        else ch = pool[$urandom_range(0, 11)];
        step($urandom_range(0, 9) != 0, ch);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smart_house_cmd_decoder.md
# smart_house_cmd_decoder

Front-end stage of the smart-house controller: consumes a byte stream of ASCII commands from the keypad/serial link and turns it into the request signals consumed by `smart_house_function` (`music_req`, `light_req`, `curtain_req`, `temp_req`, `char_req`). It parses single-letter toggle commands and a multi-digit temperature set-point command, validates them, and flags malformed or stalled input.

## Interface
- `TEMP_W`, 32, width of `temp_req`
- `TEMP_DEFAULT`, 25, `temp_req` value after reset
- `TEMP_MAX`, 50, saturation ceiling for set-points
- `MAX_DIGITS`, 3, maximum digits in a set-point
- `TIMEOUT`, 16, idle cycles allowed mid-command before abort

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `char_valid`  in  1  input byte present
- `char_in`  in  8  ASCII byte
- `char_ready`  out  1  decoder can accept a byte
- `music_req`  out  1  one-cycle pulse, toggle music
- `light_req`  out  1  one-cycle pulse, toggle light
- `curtain_req`  out  1  one-cycle pulse, toggle curtain
- `temp_req`  out  TEMP_W  held temperature set-point
- `temp_update`  out  1  one-cycle pulse when `temp_req` is written
- `char_req`  out  8  last accepted byte, held
- `cmd_error`  out  1  one-cycle pulse on malformed/timed-out command

## Operation
- Byte accepted on rising edge when `char_valid && char_ready`; no acceptance otherwise.
- States: IDLE, TEMP, EXEC.
- IDLE: `'M'`(0x4D) → `music_req` pulse; `'L'`(0x4C) → `light_req`; `'C'`(0x43) → `curtain_req`; `' '`(0x20) ignored silently; `'T'`(0x54) → TEMP, accumulator and digit count cleared; any other byte → `cmd_error`, stay IDLE. Uppercase only.
- TEMP: `'0'`–`'9'` → acc = acc*10 + digit, count+1; a digit arriving when count == MAX_DIGITS → `cmd_error`, IDLE. `'#'`(0x23) with count ≥ 1 → EXEC; `'#'` with count 0 → `cmd_error`, IDLE. Any other byte → `cmd_error`, IDLE (byte not re-interpreted as a new command).
- TEMP timeout: counter cleared on entry and on every accepted byte, increments each cycle otherwise; reaching TIMEOUT → `cmd_error`, IDLE, `temp_req` unchanged.
- EXEC (exactly one cycle): `temp_req` ← min(acc, TEMP_MAX); `temp_update` pulse; return to IDLE. Clamping is not an error.
- Arithmetic in TEMP_W bits, unsigned; MAX_DIGITS=3 bounds acc ≤ 999, no overflow.
- `char_req` updated with every accepted byte, including rejected ones.

## Timing
- Reset values: `char_ready`=1, all pulses 0, `temp_req`=TEMP_DEFAULT, `char_req`=0x00, state IDLE, acc/count/timer 0.
- Reset assertion mid-command discards partial command immediately; no pulses generated.
- `char_ready` = 0 only in EXEC; 1 in IDLE and TEMP.
- `music_req`/`light_req`/`curtain_req`/`cmd_error`: high for the single cycle following the accepting edge (registered).
- `'#'` accepted at edge N → EXEC during cycle N; at edge N+1 `temp_req` written and `temp_update` high for cycle N+1 only.
- Back-to-back bytes allowed every cycle except the cycle after `'#'`.
- `char_req` valid the cycle after acceptance.
- Timeout: with last byte accepted at edge N, `cmd_error` asserted after edge N+TIMEOUT.
- Pulses never overlap: at most one of the five pulse outputs high per cycle.

## Test plan
- Reset released, no input → `temp_req`=25, `char_req`=0, all pulses 0, `char_ready`=1.
- Stream `M`,`L`,`C` on consecutive cycles → `music_req`, `light_req`, `curtain_req` each high exactly one cycle, in order, one cycle after acceptance; `char_req`=0x43 at end.
- `T`,`3`,`0`,`#` → `temp_req`=30 and `temp_update` one cycle, two edges after `'#'`; `char_ready` low for the EXEC cycle; `T`,`9`,`9`,`#` → `temp_req`=50 (clamped), no `cmd_error`.
- `T`,`1`,`2`,`3`,`4` → `cmd_error` after `'4'`, `temp_req` unchanged; `T`,`#` → `cmd_error`; `X` in IDLE → `cmd_error`; `' '` in IDLE → nothing.
- `T`,`2` then `char_valid` low for 16 cycles → `cmd_error` on 16th cycle, state IDLE, subsequent `M` works.
- `T`,`4` then `reset` low asynchronously → outputs at reset values immediately; after release `#` → `cmd_error` (IDLE), `temp_req`=25.
